// File: rtl/npu_pkg.sv
// Shared types and default latencies for the NPU convolution scheduler.
package npu_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN,
        DONE
    } state_t;

    localparam int DEF_RD_LAT   = 1;
    localparam int DEF_ACC_LAT  = 12;
    localparam int DEF_POST_LAT = 4;
    localparam int TAG_PIX_W    = 16;

    typedef struct packed {
        logic                 valid;
        logic                 first;
        logic                 last;
        logic [TAG_PIX_W-1:0] pix;
    } tag_t;

endpackage

// File: rtl/npu_conv_scheduler_tag_delay.sv
// Fixed-depth shift register carrying beat tags alongside the MAC pipeline.
module npu_tag_delay
    import npu_pkg::*;
#(
    parameter int DEPTH = 1
) (
    input  logic clk,
    input  logic rst,
    input  tag_t d,
    output tag_t q
);

    tag_t sr [DEPTH];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) sr[i] <= '0;
        end else begin
            sr[0] <= d;
            for (int i = 1; i < DEPTH; i++) sr[i] <= sr[i-1];
        end
    end

    assign q = sr[DEPTH-1];

endmodule

// File: rtl/npu_conv_scheduler.sv
// Issues one 9-input beat per cycle over pixels x channel groups and
// tags beats so accumulator restart and result strobes meet the MAC core.
module npu_conv_scheduler
    import npu_pkg::*;
#(
    parameter int MAC_OUT_NUM = 18,
    parameter int ADDR_W      = 16,
    parameter int PIX_W       = TAG_PIX_W,
    parameter int GRP_W       = 8,
    parameter int RD_LAT      = DEF_RD_LAT,
    parameter int ACC_LAT     = DEF_ACC_LAT,
    parameter int POST_LAT    = DEF_POST_LAT
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [PIX_W-1:0]       cfg_num_pix,
    input  logic [GRP_W-1:0]       cfg_num_grp,
    input  logic [ADDR_W-1:0]      cfg_data_base,
    input  logic [ADDR_W-1:0]      cfg_weight_base,
    input  logic [3:0]             cfg_scale,
    input  logic                   hold,
    output logic                   data_rd_en,
    output logic [ADDR_W-1:0]      data_rd_addr,
    output logic                   weight_rd_en,
    output logic [ADDR_W-1:0]      weight_rd_addr,
    output logic                   MAC_data_valid_in,
    output logic                   MAC_weight_valid_in,
    output logic [MAC_OUT_NUM-1:0] adder_rst,
    output logic [3:0]             MAC_scale_in,
    output logic                   out_valid,
    output logic [PIX_W-1:0]       out_pix_idx,
    output logic                   busy,
    output logic                   done
);

    localparam int DRAIN_LEN = RD_LAT + ACC_LAT + POST_LAT;

    state_t            state;
    logic [PIX_W-1:0]  num_pix_r, p;
    logic [GRP_W-1:0]  num_grp_r, g;
    logic [ADDR_W-1:0] wbase_r, daddr, waddr;
    logic [7:0]        drain_cnt;
    logic [RD_LAT-1:0] rd_sr;
    logic              issue, g_last, p_last;
    tag_t              tag_in, tag_acc, tag_out;
    logic              unused;

    assign issue  = (state == RUN) && !hold;
    assign g_last = (g == num_grp_r - GRP_W'(1));
    assign p_last = (p == num_pix_r - PIX_W'(1));

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            busy         <= 1'b0;
            done         <= 1'b0;
            num_pix_r    <= '0;
            num_grp_r    <= '0;
            wbase_r      <= '0;
            MAC_scale_in <= '0;
            p            <= '0;
            g            <= '0;
            daddr        <= '0;
            waddr        <= '0;
            drain_cnt    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    busy <= start;
                    if (start) begin
                        num_pix_r    <= cfg_num_pix;
                        num_grp_r    <= cfg_num_grp;
                        wbase_r      <= cfg_weight_base;
                        MAC_scale_in <= cfg_scale;
                        p            <= '0;
                        g            <= '0;
                        daddr        <= cfg_data_base;
                        waddr        <= cfg_weight_base;
                        if (cfg_num_pix == '0 || cfg_num_grp == '0)
                            state <= DONE;
                        else
                            state <= RUN;
                    end
                end
                RUN: begin
                    if (!hold) begin
                        // Data address is p*num_grp+g, so it simply steps by one.
                        daddr <= daddr + ADDR_W'(1);
                        if (g_last) begin
                            g     <= '0;
                            waddr <= wbase_r;
                            p     <= p + PIX_W'(1);
                        end else begin
                            g     <= g + GRP_W'(1);
                            waddr <= waddr + ADDR_W'(1);
                        end
                        if (g_last && p_last) begin
                            state     <= DRAIN;
                            drain_cnt <= 8'(DRAIN_LEN - 1);
                        end
                    end
                end
                DRAIN: begin
                    if (drain_cnt == '0)
                        state <= DONE;
                    else
                        drain_cnt <= drain_cnt - 8'd1;
                end
                DONE: begin
                    state <= IDLE;
                    done  <= 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_sr <= '0;
        end else begin
            rd_sr[0] <= issue;
            for (int i = 1; i < RD_LAT; i++) rd_sr[i] <= rd_sr[i-1];
        end
    end

    always_comb begin
        tag_in       = '0;
        tag_in.valid = issue;
        tag_in.first = issue && (g == '0);
        tag_in.last  = issue && g_last;
        tag_in.pix   = issue ? p : '0;
    end

    npu_tag_delay #(.DEPTH(RD_LAT + ACC_LAT)) u_acc_delay (
        .clk (clk),
        .rst (rst),
        .d   (tag_in),
        .q   (tag_acc)
    );

    npu_tag_delay #(.DEPTH(POST_LAT)) u_post_delay (
        .clk (clk),
        .rst (rst),
        .d   (tag_acc),
        .q   (tag_out)
    );

    assign data_rd_en          = issue;
    assign weight_rd_en        = issue;
    assign data_rd_addr        = daddr;
    assign weight_rd_addr      = waddr;
    assign MAC_data_valid_in   = rd_sr[RD_LAT-1];
    assign MAC_weight_valid_in = rd_sr[RD_LAT-1];
    assign adder_rst   = {MAC_OUT_NUM{tag_acc.valid & tag_acc.first}};
    assign out_valid   = tag_out.valid & tag_out.last;
    assign out_pix_idx = out_valid ? tag_out.pix : '0;
    assign unused      = tag_out.first;

endmodule

// File: tb/tb_npu_conv_scheduler.sv
// Directed bench for npu_conv_scheduler: per-cycle logs after start,
// compared against hand-computed cycle positions and addresses.
module tb_npu_conv_scheduler;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [15:0] cfg_num_pix = '0;
    logic [7:0]  cfg_num_grp = '0;
    logic [15:0] cfg_data_base = '0;
    logic [15:0] cfg_weight_base = '0;
    logic [3:0]  cfg_scale = '0;
    logic        hold = 1'b0;
    logic        data_rd_en, weight_rd_en;
    logic [15:0] data_rd_addr, weight_rd_addr;
    logic        MAC_data_valid_in, MAC_weight_valid_in;
    logic [17:0] adder_rst;
    logic [3:0]  MAC_scale_in;
    logic        out_valid;
    logic [15:0] out_pix_idx;
    logic        busy, done;

    always #5 clk = ~clk;

    npu_conv_scheduler dut (
        .clk                 (clk),
        .rst                 (rst),
        .start               (start),
        .cfg_num_pix         (cfg_num_pix),
        .cfg_num_grp         (cfg_num_grp),
        .cfg_data_base       (cfg_data_base),
        .cfg_weight_base     (cfg_weight_base),
        .cfg_scale           (cfg_scale),
        .hold                (hold),
        .data_rd_en          (data_rd_en),
        .data_rd_addr        (data_rd_addr),
        .weight_rd_en        (weight_rd_en),
        .weight_rd_addr      (weight_rd_addr),
        .MAC_data_valid_in   (MAC_data_valid_in),
        .MAC_weight_valid_in (MAC_weight_valid_in),
        .adder_rst           (adder_rst),
        .MAC_scale_in        (MAC_scale_in),
        .out_valid           (out_valid),
        .out_pix_idx         (out_pix_idx),
        .busy                (busy),
        .done                (done)
    );

    int n_chk = 0;
    int n_pass = 0;

    logic        lg_rd   [64];
    logic        lg_wrd  [64];
    logic        lg_mac  [64];
    logic        lg_ov   [64];
    logic        lg_done [64];
    logic        lg_busy [64];
    logic [17:0] lg_arst [64];
    logic [15:0] lg_da   [64];
    logic [15:0] lg_wa   [64];
    logic [15:0] lg_pix  [64];
    logic [3:0]  lg_scale[64];

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    function automatic int cnt_ov(input int a, input int b);
        int c = 0;
        for (int i = a; i <= b; i++) if (lg_ov[i]) c++;
        return c;
    endfunction

    function automatic int cnt_arst(input int a, input int b);
        int c = 0;
        for (int i = a; i <= b; i++) if (lg_arst[i] != '0) c++;
        return c;
    endfunction

    function automatic int cnt_rd(input int a, input int b);
        int c = 0;
        for (int i = a; i <= b; i++) if (lg_rd[i] || lg_wrd[i]) c++;
        return c;
    endfunction

    function automatic int cnt_done(input int a, input int b);
        int c = 0;
        for (int i = a; i <= b; i++) if (lg_done[i]) c++;
        return c;
    endfunction

    // Cycle 0 carries start; cycle n is sampled at the negedge n edges later.
    task automatic run_job(input logic [15:0] pix, input logic [7:0] grp,
                           input logic [15:0] db, input logic [15:0] wb,
                           input logic [3:0] sc, input logic [63:0] hm,
                           input logic [63:0] sm, input logic [63:0] rm,
                           input int ncyc);
        for (int i = 0; i < 64; i++) begin
            lg_rd[i] = 0; lg_wrd[i] = 0; lg_mac[i] = 0; lg_ov[i] = 0;
            lg_done[i] = 0; lg_busy[i] = 0; lg_arst[i] = '0;
            lg_da[i] = '0; lg_wa[i] = '0; lg_pix[i] = '0; lg_scale[i] = '0;
        end
        @(posedge clk); #1;
        start = 1'b1; hold = 1'b0;
        cfg_num_pix = pix; cfg_num_grp = grp;
        cfg_data_base = db; cfg_weight_base = wb; cfg_scale = sc;
        for (int n = 1; n <= ncyc; n++) begin
            @(posedge clk); #1;
            start = sm[n]; hold = hm[n]; rst = rm[n];
            @(negedge clk);
            lg_rd[n]    = data_rd_en;
            lg_wrd[n]   = weight_rd_en;
            lg_mac[n]   = MAC_data_valid_in & MAC_weight_valid_in;
            lg_ov[n]    = out_valid;
            lg_done[n]  = done;
            lg_busy[n]  = busy;
            lg_arst[n]  = adder_rst;
            lg_da[n]    = data_rd_addr;
            lg_wa[n]    = weight_rd_addr;
            lg_pix[n]   = out_pix_idx;
            lg_scale[n] = MAC_scale_in;
        end
        start = 1'b0; hold = 1'b0; rst = 1'b0;
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_rd_en", {31'd0, data_rd_en}, 32'd0);
        chk("rst_addr", {16'd0, data_rd_addr}, 32'd0);
        chk("rst_arst", {14'd0, adder_rst}, 32'd0);
        chk("rst_ov", {31'd0, out_valid}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_scale", {28'd0, MAC_scale_in}, 32'd0);

        // 2 pixels x 3 groups, no hold
        run_job(16'd2, 8'd3, 16'h0100, 16'h0020, 4'd5, '0, '0, '0, 27);
        for (int n = 1; n <= 6; n++) begin
            chk("j1_rd_en", {31'd0, lg_rd[n]}, 32'd1);
            chk("j1_daddr", {16'd0, lg_da[n]}, 32'h100 + 32'(n - 1));
            chk("j1_waddr", {16'd0, lg_wa[n]}, 32'h20 + 32'((n - 1) % 3));
        end
        chk("j1_rd_stop", {31'd0, lg_rd[7]}, 32'd0);
        chk("j1_rd_cnt", 32'(cnt_rd(1, 27)), 32'd6);
        chk("j1_mac_first", {31'd0, lg_mac[2]}, 32'd1);
        chk("j1_mac_pre", {31'd0, lg_mac[1]}, 32'd0);
        chk("j1_mac_last", {31'd0, lg_mac[7]}, 32'd1);
        chk("j1_mac_post", {31'd0, lg_mac[8]}, 32'd0);
        chk("j1_arst14", {14'd0, lg_arst[14]}, 32'h3FFFF);
        chk("j1_arst17", {14'd0, lg_arst[17]}, 32'h3FFFF);
        chk("j1_arst_cnt", 32'(cnt_arst(1, 27)), 32'd2);
        chk("j1_ov20", {31'd0, lg_ov[20]}, 32'd1);
        chk("j1_pix20", {16'd0, lg_pix[20]}, 32'd0);
        chk("j1_ov23", {31'd0, lg_ov[23]}, 32'd1);
        chk("j1_pix23", {16'd0, lg_pix[23]}, 32'd1);
        chk("j1_ov_cnt", 32'(cnt_ov(1, 27)), 32'd2);
        chk("j1_done25", {31'd0, lg_done[25]}, 32'd1);
        chk("j1_done_cnt", 32'(cnt_done(1, 27)), 32'd1);
        chk("j1_busy1", {31'd0, lg_busy[1]}, 32'd1);
        chk("j1_busy25", {31'd0, lg_busy[25]}, 32'd1);
        chk("j1_busy26", {31'd0, lg_busy[26]}, 32'd0);
        chk("j1_scale", {28'd0, lg_scale[10]}, 32'd5);

        // single group per pixel: first and last on the same beat
        run_job(16'd4, 8'd1, 16'h0000, 16'h0000, 4'd2, '0, '0, '0, 25);
        for (int k = 0; k < 4; k++) begin
            chk("j2_arst", {14'd0, lg_arst[14 + k]}, 32'h3FFFF);
            chk("j2_ov", {31'd0, lg_ov[18 + k]}, 32'd1);
            chk("j2_pix", {16'd0, lg_pix[18 + k]}, 32'(k));
        end
        chk("j2_arst_cnt", 32'(cnt_arst(1, 25)), 32'd4);
        chk("j2_ov_cnt", 32'(cnt_ov(1, 25)), 32'd4);
        chk("j2_done23", {31'd0, lg_done[23]}, 32'd1);

        // hold during RUN cycles 2 and 3
        run_job(16'd1, 8'd4, 16'h0040, 16'h0008, 4'd1, 64'hC, '0, '0, 27);
        chk("j3_rd1", {31'd0, lg_rd[1]}, 32'd1);
        chk("j3_hold2", {31'd0, lg_rd[2]}, 32'd0);
        chk("j3_hold3", {31'd0, lg_rd[3]}, 32'd0);
        chk("j3_da1", {16'd0, lg_da[1]}, 32'h40);
        chk("j3_da4", {16'd0, lg_da[4]}, 32'h41);
        chk("j3_da6", {16'd0, lg_da[6]}, 32'h43);
        chk("j3_wa6", {16'd0, lg_wa[6]}, 32'h0B);
        chk("j3_rd_cnt", 32'(cnt_rd(1, 27)), 32'd4);
        chk("j3_arst14", {14'd0, lg_arst[14]}, 32'h3FFFF);
        chk("j3_arst_cnt", 32'(cnt_arst(1, 27)), 32'd1);
        chk("j3_ov21", {31'd0, lg_ov[21]}, 32'd0);
        chk("j3_ov23", {31'd0, lg_ov[23]}, 32'd1);
        chk("j3_ov_cnt", 32'(cnt_ov(1, 27)), 32'd1);
        chk("j3_done25", {31'd0, lg_done[25]}, 32'd1);

        // address wrap on both buffers
        run_job(16'd1, 8'd4, 16'hFFFE, 16'hFFFF, 4'd0, '0, '0, '0, 25);
        chk("j4_da1", {16'd0, lg_da[1]}, 32'hFFFE);
        chk("j4_da2", {16'd0, lg_da[2]}, 32'hFFFF);
        chk("j4_da3", {16'd0, lg_da[3]}, 32'h0000);
        chk("j4_da4", {16'd0, lg_da[4]}, 32'h0001);
        chk("j4_wa2", {16'd0, lg_wa[2]}, 32'h0000);
        chk("j4_wa4", {16'd0, lg_wa[4]}, 32'h0002);
        chk("j4_done23", {31'd0, lg_done[23]}, 32'd1);

        // empty job goes straight to DONE
        run_job(16'd0, 8'd3, 16'h0100, 16'h0020, 4'd3, '0, '0, '0, 6);
        chk("j5_busy1", {31'd0, lg_busy[1]}, 32'd1);
        chk("j5_done1", {31'd0, lg_done[1]}, 32'd0);
        chk("j5_done2", {31'd0, lg_done[2]}, 32'd1);
        chk("j5_rd_cnt", 32'(cnt_rd(1, 6)), 32'd0);
        chk("j5_ov_cnt", 32'(cnt_ov(1, 6)), 32'd0);
        chk("j5_busy3", {31'd0, lg_busy[3]}, 32'd0);

        // stray start in cycle 3, reset in cycle 5
        run_job(16'd4, 8'd3, 16'h0100, 16'h0020, 4'd7, '0, 64'h8, 64'h20, 40);
        chk("j6_no_restart", {16'd0, lg_da[4]}, 32'h103);
        chk("j6_busy4", {31'd0, lg_busy[4]}, 32'd1);
        chk("j6_rd_after", 32'(cnt_rd(6, 40)), 32'd0);
        chk("j6_ov_cnt", 32'(cnt_ov(1, 40)), 32'd0);
        chk("j6_arst_cnt", 32'(cnt_arst(1, 40)), 32'd0);
        chk("j6_done_cnt", 32'(cnt_done(1, 40)), 32'd0);
        chk("j6_busy6", {31'd0, lg_busy[6]}, 32'd0);
        chk("j6_addr6", {16'd0, lg_da[6]}, 32'd0);
        chk("j6_scale6", {28'd0, lg_scale[6]}, 32'd0);
        chk("j6_mac7", {31'd0, lg_mac[7]}, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
